// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive-side byte FIFO behind the UART receiver
// Stores bytes on each rx-complete pulse and serves them through a registered read handshake.
module uart_rx_fifo #(
  parameter int ADDR_W   = 4,
  parameter bit DROP_ERR = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        i_rx_d,
  input  logic              i_rx_complete,
  input  logic              i_rx_error,
  input  logic              i_rd_en,
  input  logic              i_clr_ovf,
  output logic [7:0]        o_rd_d,
  output logic              o_rd_valid,
  output logic              o_empty,
  output logic              o_full,
  output logic [ADDR_W:0]   o_count,
  output logic              o_overflow,
  output logic [7:0]        o_err_cnt
);

  localparam int              DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] L_ONE   = (ADDR_W + 1)'(1);

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_empty;
  logic              r_full;
  logic              r_overflow;
  logic              r_rd_valid;
  logic [7:0]        r_rd_d;
  logic [7:0]        r_err_cnt;

  logic              w_wr_req;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_ovf_set;
  logic              w_err_evt;
  logic [ADDR_W:0]   w_count_nxt;

  assign w_wr_req  = i_rx_complete & ~(DROP_ERR & i_rx_error);
  assign w_rd_acc  = i_rd_en & ~r_empty;
  // A read on a full FIFO frees the slot the simultaneous write lands in.
  assign w_wr_acc  = w_wr_req & (~r_full | w_rd_acc);
  assign w_ovf_set = w_wr_req & r_full & ~w_rd_acc;
  assign w_err_evt = i_rx_complete & i_rx_error;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_acc) begin
      w_count_nxt = r_count + L_ONE;
    end else if (w_rd_acc && !w_wr_acc) begin
      w_count_nxt = r_count - L_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= i_rx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_d     <= 8'h00;
    end else begin
      r_count    <= w_count_nxt;
      r_empty    <= (w_count_nxt == '0);
      r_full     <= (w_count_nxt == L_DEPTH);
      r_rd_valid <= w_rd_acc;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_rd_acc) begin
        r_rd_d   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
    end
  end

  // Set has priority over clear so a lost byte is never hidden.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_set) begin
      r_overflow <= 1'b1;
    end else if (i_clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= 8'h00;
    end else if (w_err_evt && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'h01;
    end
  end

  assign o_rd_d     = r_rd_d;
  assign o_rd_valid = r_rd_valid;
  assign o_empty    = r_empty;
  assign o_full     = r_full;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  assign o_err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo, both DROP_ERR settings
// Index 1 models the DROP_ERR=1 instance, index 0 the DROP_ERR=0 instance; both share stimulus.
module tb_uart_rx_fifo;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i_rx_d;
  logic       i_rx_complete, i_rx_error, i_rd_en, i_clr_ovf;

  logic [7:0]      rd_d   [2];
  logic            rd_vld [2];
  logic            empty  [2];
  logic            full   [2];
  logic [ADDR_W:0] count  [2];
  logic            ovf    [2];
  logic [7:0]      errc   [2];

  uart_rx_fifo #(.ADDR_W(ADDR_W), .DROP_ERR(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_rx_d(i_rx_d), .i_rx_complete(i_rx_complete),
    .i_rx_error(i_rx_error), .i_rd_en(i_rd_en), .i_clr_ovf(i_clr_ovf),
    .o_rd_d(rd_d[1]), .o_rd_valid(rd_vld[1]), .o_empty(empty[1]), .o_full(full[1]),
    .o_count(count[1]), .o_overflow(ovf[1]), .o_err_cnt(errc[1])
  );

  uart_rx_fifo #(.ADDR_W(ADDR_W), .DROP_ERR(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_rx_d(i_rx_d), .i_rx_complete(i_rx_complete),
    .i_rx_error(i_rx_error), .i_rd_en(i_rd_en), .i_clr_ovf(i_clr_ovf),
    .o_rd_d(rd_d[0]), .o_rd_valid(rd_vld[0]), .o_empty(empty[0]), .o_full(full[0]),
    .o_count(count[0]), .o_overflow(ovf[0]), .o_err_cnt(errc[0])
  );

  always #10 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] mq   [2][$];
  logic [7:0] exq  [2][$];
  bit         movf [2];
  int         merr [2];
  logic [7:0] mlast[2];
  bit         mvld [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      exq[m].delete();
      movf[m]  = 1'b0;
      merr[m]  = 0;
      mlast[m] = 8'h00;
      mvld[m]  = 1'b0;
    end
  endfunction

  function automatic void model_step(int m, bit drop, bit rd, bit wc, bit we, logic [7:0] d, bit clr);
    bit rd_acc;
    bit wr_req;
    bit was_full;
    bit lost;
    rd_acc   = rd && (mq[m].size() > 0);
    wr_req   = wc && !(drop && we);
    was_full = (mq[m].size() == DEPTH);
    lost     = 1'b0;
    mvld[m]  = rd_acc;
    if (rd_acc) begin
      mlast[m] = mq[m].pop_front();
      exq[m].push_back(mlast[m]);
    end
    if (wr_req) begin
      if (!was_full || rd_acc) mq[m].push_back(d);
      else lost = 1'b1;
    end
    if (lost) movf[m] = 1'b1;
    else if (clr) movf[m] = 1'b0;
    if (wc && we && merr[m] < 255) merr[m]++;
  endfunction

  task automatic check_status();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("count[%0d]", m), 32'(count[m]), 32'(mq[m].size()));
      chk($sformatf("empty[%0d]", m), 32'(empty[m]), 32'(mq[m].size() == 0));
      chk($sformatf("full[%0d]", m),  32'(full[m]),  32'(mq[m].size() == DEPTH));
      chk($sformatf("ovf[%0d]", m),   32'(ovf[m]),   32'(movf[m]));
      chk($sformatf("errcnt[%0d]", m), 32'(errc[m]), 32'(merr[m]));
      chk($sformatf("rdvalid[%0d]", m), 32'(rd_vld[m]), 32'(mvld[m]));
      chk($sformatf("rd_d_hold[%0d]", m), 32'(rd_d[m]), 32'(mlast[m]));
    end
  endtask

  // Called at a negedge; applies one cycle of stimulus and checks state after the edge.
  task automatic step(input bit rd, input bit wc, input bit we, input logic [7:0] d, input bit clr);
    i_rd_en = rd; i_rx_complete = wc; i_rx_error = we; i_rx_d = d; i_clr_ovf = clr;
    model_step(1, 1'b1, rd, wc, we, d, clr);
    model_step(0, 1'b0, rd, wc, we, d, clr);
    @(posedge clk);
    @(negedge clk);
    i_rd_en = 0; i_rx_complete = 0; i_rx_error = 0; i_clr_ovf = 0;
    check_status();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("rst_count[%0d]", m), 32'(count[m]), 32'd0);
      chk($sformatf("rst_empty[%0d]", m), 32'(empty[m]), 32'd1);
      chk($sformatf("rst_full[%0d]", m),  32'(full[m]),  32'd0);
      chk($sformatf("rst_ovf[%0d]", m),   32'(ovf[m]),   32'd0);
      chk($sformatf("rst_err[%0d]", m),   32'(errc[m]),  32'd0);
      chk($sformatf("rst_vld[%0d]", m),   32'(rd_vld[m]), 32'd0);
      chk($sformatf("rst_rdd[%0d]", m),   32'(rd_d[m]),  32'd0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain();
    while (mq[0].size() > 0 || mq[1].size() > 0) step(1, 0, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 0);
  endtask

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (rst_n && rd_vld[m]) begin
        if (exq[m].size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL sb_unexpected[%0d]: got valid with %0h, expected no read", m, rd_d[m]);
        end else begin
          chk($sformatf("sb_data[%0d]", m), 32'(rd_d[m]), 32'(exq[m].pop_front()));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; i_rx_d = 0; i_rx_complete = 0; i_rx_error = 0; i_rd_en = 0; i_clr_ovf = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    step(0, 1, 0, 8'h55, 0);
    step(0, 1, 0, 8'hA3, 0);
    step(1, 0, 0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 0);
    chk("two_bytes_empty", 32'(empty[1]), 32'd1);

    for (int i = 0; i < 16; i++) step(0, 1, 0, 8'(i), 0);
    chk("fill16_count", 32'(count[1]), 32'd16);
    step(0, 1, 0, 8'hFF, 0);
    chk("ovf17", 32'(ovf[1]), 32'd1);
    drain();
    step(0, 0, 0, 8'h00, 1);

    for (int i = 0; i < 16; i++) step(0, 1, 0, 8'h40 + 8'(i), 0);
    step(1, 1, 0, 8'h77, 0);
    chk("full_rw_count", 32'(count[1]), 32'd16);
    chk("full_rw_noovf", 32'(ovf[1]), 32'd0);
    drain();

    do_reset();
    step(0, 1, 1, 8'h3C, 0);
    chk("drop_err_count", 32'(count[1]), 32'd0);
    chk("keep_err_count", 32'(count[0]), 32'd1);
    drain();
    step(1, 0, 0, 8'h00, 0);
    step(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 300; i++) step(0, 1, 1, 8'(i), 0);
    chk("err_sat", 32'(errc[1]), 32'hFF);
    step(0, 1, 0, 8'h11, 1);
    chk("ovf_set_wins", 32'(ovf[0]), 32'd1);
    drain();

    step(0, 0, 0, 8'h00, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h90 + 8'(i), 0);
    step(0, 0, 0, 8'h00, 0);
    do_reset();

    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 400; c++) begin
        automatic int pw = (ph == 0) ? 80 : (ph == 1) ? 20 : (ph == 2) ? 50 : 95;
        automatic int pr = (ph == 3) ? 10 : 50;
        step(($urandom_range(0, 99) < pr), ($urandom_range(0, 99) < pw),
             ($urandom_range(0, 7) == 0), 8'($urandom), ($urandom_range(0, 15) == 0));
      end
    end
    drain();
    step(0, 0, 0, 8'h00, 0);
    chk("sb_drained[1]", 32'(exq[1].size()), 32'd0);
    chk("sb_drained[0]", 32'(exq[0].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
